// File: rtl/i2s_pkg.sv
// Shared types and frame geometry for the I2S transmit controller.
// One frame carries 64 SCLK bits: 32 in the left slot, then 32 in the right slot.
package i2s_pkg;

  localparam int FRAME_BITS = 64;
  localparam int CH_BITS    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [CH_BITS-1:0] left;
    logic [CH_BITS-1:0] right;
  } pair_t;

endpackage

// File: rtl/i2s_clkgen.sv
// SCLK/LRCLK generator. SCLK toggles every SCLK_DIV clocks while running.
// LRCLK and the bit counter only move on SCLK falling edges.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic sclk,
  output logic lrclk,
  output logic frame_boundary
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS);

  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_nxt;
  logic          half_tick;

  assign half_tick = (div_cnt == DW'(SCLK_DIV - 1));
  assign bit_nxt   = bit_cnt + BW'(1);

  // The last falling SCLK edge of bit 63 ends the frame.
  assign frame_boundary = run & ~clear & half_tick & sclk &
                          (bit_cnt == BW'(FRAME_BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      lrclk   <= 1'b0;
    end else if (clear) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      lrclk   <= 1'b0;
    end else if (run) begin
      if (half_tick) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        if (sclk) begin
          bit_cnt <= bit_nxt;
          lrclk   <= (bit_nxt >= BW'(CH_BITS));
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit controller: stream FSM, one-pair holding buffer, active pair
// register, underrun flag and channel mux onto the serializer parallel input.
module i2s_tx_ctrl
  import i2s_pkg::*;
#(
  parameter int SCLK_DIV = 4,
  parameter int WIDTH    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] L_IN,
  input  logic [WIDTH-1:0] R_IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             UNDERRUN_CLR,
  output logic             SCLK,
  output logic             LRCLK,
  output logic [WIDTH-1:0] SER_DATA,
  output logic             FRAME_STB,
  output logic             UNDERRUN,
  output logic             BUSY
);

  // state | meaning
  // IDLE  | clocks parked low, counters cleared; EN starts a frame
  // RUN   | streaming, a new pair is loaded at every frame boundary
  // DRAIN | EN dropped, finishing the current frame before parking

  state_t state;
  state_t state_nxt;
  logic   frame_load;
  logic   drain_done;
  logic   frame_boundary;
  logic   accept;
  logic   hold_full;
  pair_t  hold_q;
  pair_t  active_q;
  logic   underrun_q;

  i2s_clkgen #(
    .SCLK_DIV(SCLK_DIV)
  ) u_clkgen (
    .clk           (CLK),
    .rst           (RST),
    .run           (state != IDLE),
    .clear         (state == IDLE),
    .sclk          (SCLK),
    .lrclk         (LRCLK),
    .frame_boundary(frame_boundary)
  );

  always_comb begin
    state_nxt  = state;
    frame_load = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        if (EN) begin
          state_nxt  = RUN;
          frame_load = 1'b1;
        end
      end
      RUN: begin
        if (frame_boundary) frame_load = 1'b1;
        if (!EN) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (EN) begin
          state_nxt = RUN;
          if (frame_boundary) frame_load = 1'b1;
        end else if (frame_boundary) begin
          state_nxt  = IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  assign accept = IN_VALID & ~hold_full;

  // An accept coinciding with an empty-buffer load lands in the buffer, never in active.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_q    <= '{left: L_IN, right: R_IN};
      hold_full <= 1'b1;
    end else if (frame_load && hold_full) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      active_q <= '0;
    end else if (frame_load) begin
      active_q <= hold_full ? hold_q : '0;
    end else if (drain_done) begin
      active_q <= '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                          underrun_q <= 1'b0;
    else if (frame_load && !hold_full) underrun_q <= 1'b1;
    else if (UNDERRUN_CLR)            underrun_q <= 1'b0;
  end

  // IDLE+EN decodes a load even while RST is held; keep the strobe quiet then.
  assign FRAME_STB = frame_load & ~RST;
  assign IN_READY  = ~hold_full;
  assign UNDERRUN  = underrun_q;
  assign BUSY      = (state != IDLE);
  assign SER_DATA  = LRCLK ? active_q.right : active_q.left;

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Directed bench for i2s_tx_ctrl: SCLK_DIV=4 instance for the main scenarios,
// SCLK_DIV=1 instance for fast-clock timing and async reset.
module tb_i2s_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, in_valid, uclr;
  logic [31:0] l_in, r_in;
  logic        in_ready, sclk, lrclk, frame_stb, underrun, busy;
  logic [31:0] ser_data;
  logic        en1;
  logic        in_ready1, sclk1, lrclk1, frame_stb1, underrun1, busy1;
  logic [31:0] ser_data1;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  always #5 clk = ~clk;

  i2s_tx_ctrl #(.SCLK_DIV(4), .WIDTH(32)) u_dut4 (
    .CLK(clk), .RST(rst), .EN(en), .L_IN(l_in), .R_IN(r_in),
    .IN_VALID(in_valid), .IN_READY(in_ready), .UNDERRUN_CLR(uclr),
    .SCLK(sclk), .LRCLK(lrclk), .SER_DATA(ser_data), .FRAME_STB(frame_stb),
    .UNDERRUN(underrun), .BUSY(busy)
  );

  i2s_tx_ctrl #(.SCLK_DIV(1), .WIDTH(32)) u_dut1 (
    .CLK(clk), .RST(rst), .EN(en1), .L_IN(l_in), .R_IN(r_in),
    .IN_VALID(1'b0), .IN_READY(in_ready1), .UNDERRUN_CLR(1'b0),
    .SCLK(sclk1), .LRCLK(lrclk1), .SER_DATA(ser_data1), .FRAME_STB(frame_stb1),
    .UNDERRUN(underrun1), .BUSY(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; en1 = 1'b0; in_valid = 1'b0; uclr = 1'b0;
    l_in = '0; r_in = '0;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (sclk !== 1'b0)      begin errs++; $display("FAIL rst_sclk: got %0b want 0", sclk); end
    vecs++; if (lrclk !== 1'b0)     begin errs++; $display("FAIL rst_lrclk: got %0b want 0", lrclk); end
    vecs++; if (frame_stb !== 1'b0) begin errs++; $display("FAIL rst_stb: got %0b want 0", frame_stb); end
    vecs++; if (underrun !== 1'b0)  begin errs++; $display("FAIL rst_underrun: got %0b want 0", underrun); end
    vecs++; if (busy !== 1'b0)      begin errs++; $display("FAIL rst_busy: got %0b want 0", busy); end
    vecs++; if (ser_data !== 32'h0) begin errs++; $display("FAIL rst_ser: got %h want 0", ser_data); end
    rst = 1'b0;
    tick();
    vecs++; if (in_ready !== 1'b1)  begin errs++; $display("FAIL rst_ready: got %0b want 1", in_ready); end
    vecs++; if (busy !== 1'b0)      begin errs++; $display("FAIL rst_busy_rel: got %0b want 0", busy); end
  endtask

  task automatic test_start();
    l_in = 32'hA5A5_0001; r_in = 32'h5A5A_0002; in_valid = 1'b1;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL prefill_ready: got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    vecs++; if (in_ready !== 1'b0)  begin errs++; $display("FAIL prefill_full: got %0b want 0", in_ready); end
    vecs++; if (frame_stb !== 1'b0) begin errs++; $display("FAIL idle_stb: got %0b want 0", frame_stb); end
    en = 1'b1;
    #1;
    vecs++; if (frame_stb !== 1'b1) begin errs++; $display("FAIL start_stb: got %0b want 1", frame_stb); end
    tick();
    cyc = 0;
    vecs++; if (frame_stb !== 1'b0)        begin errs++; $display("FAIL start_stb_end: got %0b want 0", frame_stb); end
    vecs++; if (busy !== 1'b1)             begin errs++; $display("FAIL start_busy: got %0b want 1", busy); end
    vecs++; if (in_ready !== 1'b1)         begin errs++; $display("FAIL start_ready: got %0b want 1", in_ready); end
    vecs++; if (ser_data !== 32'hA5A50001) begin errs++; $display("FAIL start_ser: got %h want a5a50001", ser_data); end
    go_to(3);
    vecs++; if (sclk !== 1'b0) begin errs++; $display("FAIL sclk_c3: got %0b want 0", sclk); end
    go_to(4);
    vecs++; if (sclk !== 1'b1) begin errs++; $display("FAIL sclk_c4: got %0b want 1", sclk); end
    go_to(7);
    vecs++; if (sclk !== 1'b1) begin errs++; $display("FAIL sclk_c7: got %0b want 1", sclk); end
    go_to(8);
    vecs++; if (sclk !== 1'b0)  begin errs++; $display("FAIL sclk_c8: got %0b want 0", sclk); end
    vecs++; if (lrclk !== 1'b0) begin errs++; $display("FAIL lrclk_c8: got %0b want 0", lrclk); end
    go_to(255);
    vecs++; if (lrclk !== 1'b0)            begin errs++; $display("FAIL lrclk_c255: got %0b want 0", lrclk); end
    vecs++; if (ser_data !== 32'hA5A50001) begin errs++; $display("FAIL ser_left: got %h want a5a50001", ser_data); end
    go_to(256);
    vecs++; if (lrclk !== 1'b1)            begin errs++; $display("FAIL lrclk_c256: got %0b want 1", lrclk); end
    vecs++; if (ser_data !== 32'h5A5A0002) begin errs++; $display("FAIL ser_right: got %h want 5a5a0002", ser_data); end
  endtask

  task automatic test_underrun();
    go_to(511);
    vecs++; if (frame_stb !== 1'b1) begin errs++; $display("FAIL bound_stb: got %0b want 1", frame_stb); end
    vecs++; if (underrun !== 1'b0)  begin errs++; $display("FAIL pre_underrun: got %0b want 0", underrun); end
    go_to(512);
    vecs++; if (underrun !== 1'b1)  begin errs++; $display("FAIL underrun_set: got %0b want 1", underrun); end
    vecs++; if (ser_data !== 32'h0) begin errs++; $display("FAIL ur_ser_l: got %h want 0", ser_data); end
    vecs++; if (lrclk !== 1'b0)     begin errs++; $display("FAIL ur_lrclk: got %0b want 0", lrclk); end
    go_to(768);
    vecs++; if (ser_data !== 32'h0) begin errs++; $display("FAIL ur_ser_r: got %h want 0", ser_data); end
    vecs++; if (underrun !== 1'b1)  begin errs++; $display("FAIL ur_sticky: got %0b want 1", underrun); end
    go_to(800);
    uclr = 1'b1;
    tick();
    uclr = 1'b0;
    vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL ur_clear: got %0b want 0", underrun); end
  endtask

  task automatic test_accept_on_load();
    go_to(1023);
    uclr = 1'b1; l_in = 32'h1111_0003; r_in = 32'h2222_0004; in_valid = 1'b1;
    #1;
    vecs++; if (frame_stb !== 1'b1) begin errs++; $display("FAIL acc_stb: got %0b want 1", frame_stb); end
    vecs++; if (in_ready !== 1'b1)  begin errs++; $display("FAIL acc_ready: got %0b want 1", in_ready); end
    tick();
    uclr = 1'b0; in_valid = 1'b0;
    vecs++; if (underrun !== 1'b1)  begin errs++; $display("FAIL set_wins: got %0b want 1", underrun); end
    vecs++; if (ser_data !== 32'h0) begin errs++; $display("FAIL no_bypass: got %h want 0", ser_data); end
    vecs++; if (in_ready !== 1'b0)  begin errs++; $display("FAIL acc_held: got %0b want 0", in_ready); end
    go_to(1534);
    vecs++; if (frame_stb !== 1'b0) begin errs++; $display("FAIL acc_stb_early: got %0b want 0", frame_stb); end
    go_to(1535);
    vecs++; if (frame_stb !== 1'b1) begin errs++; $display("FAIL acc_stb_next: got %0b want 1", frame_stb); end
    go_to(1536);
    vecs++; if (ser_data !== 32'h11110003) begin errs++; $display("FAIL acc_play: got %h want 11110003", ser_data); end
    vecs++; if (in_ready !== 1'b1)         begin errs++; $display("FAIL acc_ready2: got %0b want 1", in_ready); end
  endtask

  task automatic test_drain();
    go_to(1541);
    l_in = 32'h3333_0005; r_in = 32'h4444_0006; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    go_to(1618);
    en = 1'b0;
    tick();
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL drain_busy: got %0b want 1", busy); end
    go_to(1836);
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL drain_busy2: got %0b want 1", busy); end
    go_to(2047);
    vecs++; if (frame_stb !== 1'b0)        begin errs++; $display("FAIL drain_nostb: got %0b want 0", frame_stb); end
    vecs++; if (ser_data !== 32'h22220004) begin errs++; $display("FAIL drain_tail: got %h want 22220004", ser_data); end
    go_to(2048);
    vecs++; if (busy !== 1'b0)      begin errs++; $display("FAIL drain_idle: got %0b want 0", busy); end
    vecs++; if (sclk !== 1'b0)      begin errs++; $display("FAIL drain_sclk: got %0b want 0", sclk); end
    vecs++; if (lrclk !== 1'b0)     begin errs++; $display("FAIL drain_lrclk: got %0b want 0", lrclk); end
    vecs++; if (ser_data !== 32'h0) begin errs++; $display("FAIL drain_ser: got %h want 0", ser_data); end
    vecs++; if (in_ready !== 1'b0)  begin errs++; $display("FAIL drain_kept: got %0b want 0", in_ready); end
    go_to(2060);
    vecs++; if (sclk !== 1'b0)      begin errs++; $display("FAIL idle_sclk: got %0b want 0", sclk); end
    vecs++; if (frame_stb !== 1'b0) begin errs++; $display("FAIL idle_nostb: got %0b want 0", frame_stb); end
  endtask

  task automatic test_back_to_back();
    en = 1'b1;
    #1;
    vecs++; if (frame_stb !== 1'b1) begin errs++; $display("FAIL b2b_stb: got %0b want 1", frame_stb); end
    tick();
    vecs++; if (ser_data !== 32'h33330005) begin errs++; $display("FAIL b2b_play: got %h want 33330005", ser_data); end
    for (int c = 1; c <= 511; c++) begin
      if (c == 50) begin l_in = 32'h5555_0007; r_in = 32'h6666_0008; in_valid = 1'b1; end
      if (c == 51) in_valid = 1'b0;
      if (c == 100) en = 1'b0;
      if (c == 200) en = 1'b1;
      tick();
      vecs++;
      if (sclk !== 1'(((c / 4) % 2)) || busy !== 1'b1) begin
        errs++;
        $display("FAIL b2b_sclk c=%0d: got sclk=%0b busy=%0b want sclk=%0d busy=1", c, sclk, busy, (c / 4) % 2);
      end
    end
    vecs++; if (frame_stb !== 1'b1) begin errs++; $display("FAIL b2b_stb2: got %0b want 1", frame_stb); end
    tick();
    cyc = 0;
    vecs++; if (ser_data !== 32'h55550007) begin errs++; $display("FAIL b2b_play2: got %h want 55550007", ser_data); end
    vecs++; if (in_ready !== 1'b1)         begin errs++; $display("FAIL b2b_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_async_reset();
    go_to(322);
    vecs++; if (lrclk !== 1'b1)            begin errs++; $display("FAIL pre_rst_lrclk: got %0b want 1", lrclk); end
    vecs++; if (ser_data !== 32'h66660008) begin errs++; $display("FAIL pre_rst_ser: got %h want 66660008", ser_data); end
    #2;
    rst = 1'b1;
    #1;
    vecs++; if (sclk !== 1'b0)      begin errs++; $display("FAIL arst_sclk: got %0b want 0", sclk); end
    vecs++; if (lrclk !== 1'b0)     begin errs++; $display("FAIL arst_lrclk: got %0b want 0", lrclk); end
    vecs++; if (frame_stb !== 1'b0) begin errs++; $display("FAIL arst_stb: got %0b want 0", frame_stb); end
    vecs++; if (underrun !== 1'b0)  begin errs++; $display("FAIL arst_ur: got %0b want 0", underrun); end
    vecs++; if (busy !== 1'b0)      begin errs++; $display("FAIL arst_busy: got %0b want 0", busy); end
    vecs++; if (ser_data !== 32'h0) begin errs++; $display("FAIL arst_ser: got %h want 0", ser_data); end
    en = 1'b0;
    #3;
    rst = 1'b0;
    tick();
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL arst_ready: got %0b want 1", in_ready); end
    vecs++; if (busy !== 1'b0)     begin errs++; $display("FAIL arst_idle: got %0b want 0", busy); end
  endtask

  task automatic test_div1();
    en1 = 1'b1;
    #1;
    vecs++; if (frame_stb1 !== 1'b1) begin errs++; $display("FAIL d1_stb: got %0b want 1", frame_stb1); end
    tick();
    cyc = 0;
    vecs++; if (sclk1 !== 1'b0)      begin errs++; $display("FAIL d1_sclk0: got %0b want 0", sclk1); end
    vecs++; if (underrun1 !== 1'b1)  begin errs++; $display("FAIL d1_ur: got %0b want 1", underrun1); end
    vecs++; if (ser_data1 !== 32'h0) begin errs++; $display("FAIL d1_ser: got %h want 0", ser_data1); end
    go_to(1);
    vecs++; if (sclk1 !== 1'b1) begin errs++; $display("FAIL d1_sclk1: got %0b want 1", sclk1); end
    go_to(2);
    vecs++; if (sclk1 !== 1'b0) begin errs++; $display("FAIL d1_sclk2: got %0b want 0", sclk1); end
    go_to(63);
    vecs++; if (lrclk1 !== 1'b0) begin errs++; $display("FAIL d1_lr63: got %0b want 0", lrclk1); end
    go_to(64);
    vecs++; if (lrclk1 !== 1'b1) begin errs++; $display("FAIL d1_lr64: got %0b want 1", lrclk1); end
    go_to(126);
    vecs++; if (frame_stb1 !== 1'b0) begin errs++; $display("FAIL d1_stb126: got %0b want 0", frame_stb1); end
    go_to(127);
    vecs++; if (frame_stb1 !== 1'b1) begin errs++; $display("FAIL d1_stb127: got %0b want 1", frame_stb1); end
    go_to(128);
    vecs++; if (lrclk1 !== 1'b0) begin errs++; $display("FAIL d1_lr128: got %0b want 0", lrclk1); end
    go_to(208);
    vecs++; if (lrclk1 !== 1'b1) begin errs++; $display("FAIL d1_lr208: got %0b want 1", lrclk1); end
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if (sclk1 !== 1'b0 || lrclk1 !== 1'b0 || frame_stb1 !== 1'b0 ||
        underrun1 !== 1'b0 || busy1 !== 1'b0 || ser_data1 !== 32'h0) begin
      errs++;
      $display("FAIL d1_arst: got sclk=%0b lr=%0b stb=%0b ur=%0b busy=%0b ser=%h want all 0",
               sclk1, lrclk1, frame_stb1, underrun1, busy1, ser_data1);
    end
    en1 = 1'b0;
    #3;
    rst = 1'b0;
    tick();
    vecs++; if (in_ready1 !== 1'b1) begin errs++; $display("FAIL d1_ready: got %0b want 1", in_ready1); end
    vecs++; if (busy1 !== 1'b0)     begin errs++; $display("FAIL d1_idle: got %0b want 0", busy1); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_underrun();
    test_accept_on_load();
    test_drain();
    test_back_to_back();
    test_async_reset();
    test_div1();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/i2s_tx_ctrl.md
Name: i2s_tx_ctrl

Overview:
Controller and clock generator for the 32-bit I2S transmit serializer. It derives SCLK and LRCLK from the system clock and accepts stereo sample pairs from the synthesizer core over a valid/ready handshake. A one-pair holding buffer feeds an active pair register, and the controller presents the correct channel word on the serializer's parallel input. It also reports frame timing and underruns, and starts and stops the stream cleanly on frame boundaries.

Parameters:
SCLK_DIV, 4, CLK cycles per SCLK half-period; legal range ≥1; SCLK period = 2*SCLK_DIV CLK cycles
WIDTH, 32, sample word width and bits per channel slot; fixed at 32 to match the serializer

Ports:
CLK  in  1  system clock
RST  in  1  reset; asynchronous, active-high
EN  in  1  stream enable (level)
L_IN  in  WIDTH  left sample from upstream
R_IN  in  WIDTH  right sample from upstream
IN_VALID  in  1  upstream pair valid
IN_READY  out  1  holding buffer empty; pair accepted when IN_VALID&&IN_READY
UNDERRUN_CLR  in  1  clears UNDERRUN
SCLK  out  1  bit clock to serializer and DAC
LRCLK  out  1  word select; 0 = left slot, 1 = right slot
SER_DATA  out  WIDTH  parallel word to the serializer Din input
FRAME_STB  out  1  one-CLK pulse at each frame load
UNDERRUN  out  1  sticky underrun flag
BUSY  out  1  high in RUN and DRAIN

Behaviour:
- Reset (async): state IDLE; SCLK, LRCLK, FRAME_STB, UNDERRUN, BUSY, SER_DATA = 0; buffer empty, active pair = 0, div_cnt = bit_cnt = 0. IN_READY = 1 after release.
- IN_READY = ~buf_full in all states, so the buffer can be prefilled in IDLE. On accept, buf <= {L_IN,R_IN} and buf_full <= 1.
- SER_DATA = LRCLK ? active_R : active_L (registered-source mux; no CLK-to-SCLK glitch paths).
- States:
  - IDLE: SCLK = LRCLK = 0, counters held at 0. EN=1 -> RUN. The transition cycle performs a frame load.
  - RUN: each CLK, div_cnt++. When div_cnt == SCLK_DIV-1: div_cnt <= 0 and SCLK toggles. On a falling toggle (SCLK 1->0): bit_cnt <= (bit_cnt+1) mod 64 and LRCLK <= (new bit_cnt ≥ 32). A falling toggle with bit_cnt == 63 is a frame boundary and triggers a frame load. EN=0 -> DRAIN.
  - DRAIN: counting continues as in RUN. EN=1 -> RUN with no disturbance. At the next frame boundary -> IDLE with no frame load; SCLK, LRCLK, SER_DATA, counters and active pair are cleared.
- Frame load:
  - FRAME_STB = 1 for that CLK.
  - If buf_full: active <= buf and buf_full <= 0.
  - Otherwise: active <= 0 and UNDERRUN <= 1.
- LRCLK changes only on SCLK falling edges, so it is stable at the serializer's rising edges. The first SCLK rise comes SCLK_DIV CLKs after entering RUN. Frame length = 128*SCLK_DIV CLKs (512 at default).
- Simultaneous events:
  - An accept in the same cycle as a frame load with an empty buffer does not bypass: underrun is taken, and the new pair lands in the buffer for the next frame.
  - UNDERRUN_CLR together with a new underrun: set wins.
  - EN toggling within a frame never truncates a frame.
- RST mid-frame aborts immediately to reset values and discards buffered data.

Decomposition:
- Package i2s_pkg holds:
  - state enum {IDLE, RUN, DRAIN}
  - FRAME_BITS = 64 and CH_BITS = 32
  - the stereo pair struct {left, right}
- One sub-module, i2s_clkgen, contains div_cnt, bit_cnt, the SCLK/LRCLK registers and a frame_boundary pulse, with run/clear inputs. The top level contains the FSM, buffer, active pair and flags.

Test Plan:
- SCLK_DIV=4; prefill {L=0xA5A5_0001, R=0x5A5A_0002}; EN=1 -> FRAME_STB pulses on the transition cycle; SCLK period 8 CLK; LRCLK rises after 32 SCLK falls; SER_DATA = 0xA5A5_0001 while LRCLK=0 and 0x5A5A_0002 while LRCLK=1; IN_READY returns to 1.
- Keep the buffer empty at the second frame boundary -> SER_DATA = 0 for the whole frame, UNDERRUN = 1 and stays set; UNDERRUN_CLR pulse -> 0; CLR coinciding with a fresh underrun -> stays 1.
- Push a pair the same cycle as an underrun frame load -> the frame plays zeros; the pair plays in the following frame (next FRAME_STB 512 CLK later).
- Drop EN at bit_cnt=10 -> BUSY stays 1; the frame completes; IDLE is reached at the boundary with SCLK = LRCLK = SER_DATA = 0, no FRAME_STB, and buffer contents retained.
- Drop EN, then re-raise it before the boundary -> continuous SCLK with no gap and normal frame loads.
- Assert RST at bit_cnt=40 -> all outputs 0 immediately (async); after release IN_READY=1 and state is IDLE. Repeat with SCLK_DIV=1 -> SCLK period 2 CLK, frame 128 CLK.
